// File: rtl/mipi_dsi_line_pkt_gen.sv
// Per-line DSI HS burst builder: sync short packet, then an optional RGB888 long packet
// (header, payload, CRC16) spread over four byte lanes, with paced pixel fetch from a line buffer.
module mipi_dsi_line_pkt_gen #(
  parameter int         H_ACTIVE  = 480,
  parameter logic [1:0] VC        = 2'd0,
  parameter logic [5:0] DATA_TYPE = 6'h3E,
  parameter bit         CRC_EN    = 1'b1,
  parameter int         MIN_GAP   = 104
) (
  input  logic        I_lcd_clk,
  input  logic        I_rst_n,
  input  logic        I_enable,
  input  logic        I_line_start,
  input  logic        I_frame_start,
  input  logic        I_line_active,
  output logic        O_pix_rd,
  input  logic [47:0] I_pix_data,
  output logic        O_hs_en,
  output logic [7:0]  O_hs_rgb_lane0,
  output logic [7:0]  O_hs_rgb_lane1,
  output logic [7:0]  O_hs_rgb_lane2,
  output logic [7:0]  O_hs_rgb_lane3,
  output logic        O_busy,
  output logic        O_overrun
);
  localparam int NUM_LANES = 4;
  localparam int SBUF_B    = 12;
  localparam int PAY_CYC   = 3 * H_ACTIVE / 4;
  localparam int NUM_RD    = H_ACTIVE / 2;
  localparam int PW        = $clog2(PAY_CYC + 1);
  localparam int RW        = $clog2(NUM_RD + 1);
  localparam int GW        = $clog2(MIN_GAP + 1);
  localparam logic [PW-1:0] PAY_LAST = PW'(PAY_CYC - 1);
  localparam logic [RW-1:0] RD_INIT  = RW'(NUM_RD - 1);
  localparam logic [GW-1:0] GAP_INIT = GW'(MIN_GAP);
  localparam logic [15:0]   WC       = 16'(3 * H_ACTIVE);
  localparam logic [7:0]    LONG_DI  = {VC, DATA_TYPE};

  function automatic logic [7:0] ecc24(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return {2'b00, p};
  endfunction

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  localparam logic [7:0] HDR_ECC = ecc24({WC, LONG_DI});

  typedef enum logic [2:0] {S_IDLE, S_SHORT, S_HDR, S_PAY, S_CRC, S_GAP} state_t;

  state_t                          state;
  logic [PW-1:0]                   pay_cnt;
  logic [GW-1:0]                   gap_cnt;
  logic [RW-1:0]                   rd_left;
  logic                            line_act;
  logic [15:0]                     crc;
  logic [SBUF_B-1:0][7:0]          sbuf;
  logic [3:0]                      sbuf_cnt;
  logic [1:0]                      vld_pipe;
  logic [NUM_LANES-1:0][7:0]       lane_q;
  logic                            hs_en_q, busy_q, ovr_q;

  logic                            accept, start_rd, cons_now, cons_next, rd_issue;
  logic [5:0][7:0]                 pix_b;
  logic [SBUF_B-1:0][7:0]          cat, sbuf_nx;
  logic [4:0]                      cat_cnt;
  logic [3:0]                      sbuf_cnt_nx;
  logic [15:0]                     crc_fold, crc_o;
  logic [7:0]                      sdi, secc;
  int                              proj;

  assign accept   = I_line_start & I_enable &
                    ((state == S_IDLE) | ((state == S_GAP) & (gap_cnt == '0)));
  assign start_rd = accept & I_line_active;
  assign sdi      = {VC, I_frame_start ? 6'h01 : 6'h21};
  assign secc     = ecc24({16'h0000, sdi});
  assign crc_o    = CRC_EN ? crc : 16'h0000;

  // Staging buffer: bytes already held plus the word landing this edge, oldest at index 0.
  always_comb begin
    cons_now  = (state == S_HDR) | ((state == S_PAY) & (pay_cnt != PAY_LAST));
    cons_next = 1'b0;
    case (state)
      S_SHORT: cons_next = line_act;
      S_HDR:   cons_next = (PAY_LAST != '0);
      S_PAY:   cons_next = (pay_cnt != PAY_LAST) & ((pay_cnt + 1'b1) != PAY_LAST);
      default: cons_next = 1'b0;
    endcase
    for (int j = 0; j < 6; j++) pix_b[j] = I_pix_data[47-8*j -: 8];
    cat     = sbuf;
    cat_cnt = {1'b0, sbuf_cnt} + (vld_pipe[1] ? 5'd6 : 5'd0);
    if (vld_pipe[1])
      for (int i = 0; i < SBUF_B; i++)
        for (int j = 0; j < 6; j++)
          if (int'(sbuf_cnt) + j == i) cat[i] = pix_b[j];
    sbuf_nx     = cat;
    sbuf_cnt_nx = cat_cnt[3:0];
    if (cons_now) begin
      sbuf_nx = '0;
      for (int i = 0; i < SBUF_B - 4; i++) sbuf_nx[i] = cat[i+4];
      sbuf_cnt_nx = 4'(cat_cnt - 5'd4);
    end
    crc_fold = crc;
    for (int l = 0; l < NUM_LANES; l++) crc_fold = crc_upd(crc_fold, cat[l]);
    // Issue a read only when the bytes left after the next edge would not cover the one after.
    proj = int'(cat_cnt) - (cons_now ? 4 : 0) + (vld_pipe[0] ? 6 : 0) - (cons_next ? 4 : 0);
    rd_issue = start_rd |
               (((state == S_SHORT) | (state == S_HDR) | (state == S_PAY)) &
                (rd_left != '0) & (proj < 4));
  end

  always_ff @(posedge I_lcd_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state    <= S_IDLE;
      pay_cnt  <= '0;
      gap_cnt  <= '0;
      rd_left  <= '0;
      line_act <= 1'b0;
      crc      <= 16'hFFFF;
      sbuf     <= '0;
      sbuf_cnt <= '0;
      vld_pipe <= '0;
      lane_q   <= '0;
      hs_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      ovr_q    <= I_line_start & I_enable & ~accept;
      vld_pipe <= {vld_pipe[0], rd_issue};
      sbuf     <= sbuf_nx;
      sbuf_cnt <= sbuf_cnt_nx;
      hs_en_q  <= 1'b0;
      lane_q   <= '0;
      if (accept) rd_left <= I_line_active ? RD_INIT : '0;
      else if (rd_issue) rd_left <= rd_left - 1'b1;
      if (accept) begin
        state    <= S_SHORT;
        busy_q   <= 1'b1;
        hs_en_q  <= 1'b1;
        lane_q   <= {secc, 8'h00, 8'h00, sdi};
        line_act <= I_line_active;
      end else begin
        case (state)
          S_SHORT: begin
            crc <= 16'hFFFF;
            if (line_act) begin
              state   <= S_HDR;
              hs_en_q <= 1'b1;
              lane_q  <= {HDR_ECC, WC[15:8], WC[7:0], LONG_DI};
            end else begin
              state   <= S_GAP;
              gap_cnt <= GAP_INIT;
            end
          end
          S_HDR: begin
            state   <= S_PAY;
            pay_cnt <= '0;
            hs_en_q <= 1'b1;
            lane_q  <= cat[NUM_LANES-1:0];
            crc     <= crc_fold;
          end
          S_PAY: begin
            hs_en_q <= 1'b1;
            if (pay_cnt != PAY_LAST) begin
              pay_cnt <= pay_cnt + 1'b1;
              lane_q  <= cat[NUM_LANES-1:0];
              crc     <= crc_fold;
            end else begin
              state  <= S_CRC;
              lane_q <= {8'h00, 8'h00, crc_o[15:8], crc_o[7:0]};
            end
          end
          S_CRC: begin
            state   <= S_GAP;
            gap_cnt <= GAP_INIT;
          end
          S_GAP: begin
            // Spans MIN_GAP+1 cycles; a request on the last one chains straight into SHORT.
            if (gap_cnt == '0) begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign O_pix_rd       = vld_pipe[0];
  assign O_hs_en        = hs_en_q;
  assign O_hs_rgb_lane0 = lane_q[0];
  assign O_hs_rgb_lane1 = lane_q[1];
  assign O_hs_rgb_lane2 = lane_q[2];
  assign O_hs_rgb_lane3 = lane_q[3];
  assign O_busy         = busy_q;
  assign O_overrun      = ovr_q;
endmodule
